mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory arbiter.
// Round-robin arbitration is enabled by defining ARB_RR_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between I and D requesters.
// ARB_RR_EN selects round-robin; otherwise fixed D priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last,
  output logic grant_d
);

`ifdef ARB_RR_EN
  assign grant_d = d_req & (~i_req | (last == REQ_I));
`else
  logic unused;
  assign unused  = i_req ^ last;
  assign grant_d = d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I/D cache) arbiter onto one shared memory port.
// ARB_RR_EN selects round-robin; default is fixed D priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   grant_d;
  logic   last;

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;

`ifdef ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_I;
    end else if (state == IDLE && (i_req | d_req)) begin
      last_q <= grant_d;
    end
  end

  assign last = last_q;
`else
  assign last = REQ_I;
`endif

  mem_arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .last    (last),
    .grant_d (grant_d)
  );

  // A simultaneous read+write is issued as a write only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req | d_req) begin
            if (grant_d) begin
              state     <= SERVE_D;
              mem_read  <= d_mem_read & ~d_mem_write;
              mem_write <= d_mem_write;
              mem_addr  <= d_mem_addr;
              mem_wdata <= d_mem_wdata;
            end else begin
              state     <= SERVE_I;
              mem_read  <= i_mem_read & ~i_mem_write;
              mem_write <= i_mem_write;
              mem_addr  <= i_mem_addr;
              mem_wdata <= i_mem_wdata;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_ready) begin
            state     <= RELEASE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign i_mem_ready = (state == SERVE_I) & mem_ready;
  assign d_mem_ready = (state == SERVE_D) & mem_ready;
  assign i_mem_rdata = (state == SERVE_I) ? mem_rdata : '0;
  assign d_mem_rdata = (state == SERVE_D) ? mem_rdata : '0;

endmodule
